btn_sw_array: RTL and testbench

BTN_SW_ARRAY -- requirements
Module: btn_sw_array

---
 rtl/btn_sw_pkg.sv | 13 +
 rtl/btn_sw_chan.sv | 93 +++++++++
 rtl/btn_sw_array.sv | 38 +++
 tb/tb_btn_sw_array.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_sw_pkg.sv
// Shared definitions for the debounced button/switch array.
package btn_sw_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    function automatic int unsigned cnt_width(input int unsigned db_cycles);
        return $clog2(db_cycles + 1);
    endfunction

endpackage

// File: rtl/btn_sw_chan.sv
// One channel: 2-flop synchroniser, debounce counter, edge detect and the
// toggle/output registers.
module btn_sw_chan
    import btn_sw_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = 16,
    parameter logic        RESETVAL    = 1'b0,
    parameter logic        NEGEDGESENS = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic in_i,
    input  logic mode_i,
    input  logic clr_i,
    output logic sw_o,
    output logic pulse_o
);

    localparam int unsigned   CW    = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(DB_CYCLES - 1);

    mode_e         mode_s;
    logic          sync1_q, sync2_q;
    logic          stb_q, stb_d;
    logic          stb_dly_q, stb_dly_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tog_q, tog_d;
    logic          sw_q, sw_d;
    logic          pulse_q, pulse_d;
    logic          act_edge, any_edge;

    assign mode_s   = mode_e'(mode_i);
    assign any_edge = stb_q ^ stb_dly_q;
    assign act_edge = NEGEDGESENS ? (~stb_q & stb_dly_q) : (stb_q & ~stb_dly_q);

    always_comb begin
        stb_d     = stb_q;
        stb_dly_d = stb_dly_q;
        cnt_d     = cnt_q;
        tog_d     = tog_q;
        sw_d      = sw_q;
        pulse_d   = 1'b0;
        if (en) begin
            if (sync2_q != stb_q) begin
                if (cnt_q == LIMIT) begin
                    stb_d = sync2_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
            // stb_dly only advances while enabled, so an edge that lands just
            // before a freeze is still reported once en returns.
            stb_dly_d = stb_q;
            if (clr_i) begin
                tog_d = RESETVAL;
            end else if (mode_s == MODE_TOGGLE && act_edge) begin
                tog_d = ~tog_q;
            end
            pulse_d = (mode_s == MODE_PULSE) ? any_edge : act_edge;
            sw_d    = (mode_s == MODE_PULSE) ? stb_q : tog_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= NEGEDGESENS;
            sync2_q   <= NEGEDGESENS;
            stb_q     <= NEGEDGESENS;
            stb_dly_q <= NEGEDGESENS;
            cnt_q     <= '0;
            tog_q     <= RESETVAL;
            sw_q      <= (mode_s == MODE_TOGGLE) ? RESETVAL : NEGEDGESENS;
            pulse_q   <= 1'b0;
        end else begin
            sync1_q   <= in_i;
            sync2_q   <= sync1_q;
            stb_q     <= stb_d;
            stb_dly_q <= stb_dly_d;
            cnt_q     <= cnt_d;
            tog_q     <= tog_d;
            sw_q      <= sw_d;
            pulse_q   <= pulse_d;
        end
    end

    assign sw_o    = sw_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/btn_sw_array.sv
// Array of CH independent debounced button/switch channels with per-channel
// toggle or pulse mode.
module btn_sw_array
    import btn_sw_pkg::*;
#(
    parameter int unsigned CH          = 4,
    parameter int unsigned DB_CYCLES   = 16,
    parameter logic        RESETVAL    = 1'b0,
    parameter logic        NEGEDGESENS = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CH-1:0] in,
    input  logic [CH-1:0] mode,
    input  logic [CH-1:0] clr,
    output logic [CH-1:0] sw_out,
    output logic [CH-1:0] pulse_out
);

    for (genvar g = 0; g < CH; g++) begin : g_chan
        btn_sw_chan #(
            .DB_CYCLES  (DB_CYCLES),
            .RESETVAL   (RESETVAL),
            .NEGEDGESENS(NEGEDGESENS)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .in_i   (in[g]),
            .mode_i (mode[g]),
            .clr_i  (clr[g]),
            .sw_o   (sw_out[g]),
            .pulse_o(pulse_out[g])
        );
    end

endmodule

// File: tb/tb_btn_sw_array.sv
// Bench for btn_sw_array: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_btn_sw_array;

    localparam int   CH  = 4;
    localparam int   DB  = 4;
    localparam logic RV  = 1'b0;
    localparam logic NEG = 1'b0;

    logic          clk = 1'b0;
    logic          rst, en;
    logic [CH-1:0] in_v, mode_v, clr_v;
    logic [CH-1:0] sw_out, pulse_out;

    always #5 clk = ~clk;

    btn_sw_array #(
        .CH         (CH),
        .DB_CYCLES  (DB),
        .RESETVAL   (RV),
        .NEGEDGESENS(NEG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in       (in_v),
        .mode     (mode_v),
        .clr      (clr_v),
        .sw_out   (sw_out),
        .pulse_out(pulse_out)
    );

    int passed = 0;
    int total  = 0;
    bit chk_on = 1'b0;

    // Model: level seen by the debouncer lags the pin by two samples; the
    // stable level flips once the lagged pin has disagreed for DB enabled
    // cycles in a row; events are reported one cycle after the flip.
    logic [CH-1:0] m_s1 = '0, m_s2 = '0, m_stb = '0, m_seen = '0;
    logic [CH-1:0] m_tog = '0, m_sw = '0, m_pl = '0;
    int            m_run [CH];

    logic [CH-1:0] acc;

    task automatic check(input string name, input logic [CH-1:0] got, input logic [CH-1:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, got, exp);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic model_step();
        for (int c = 0; c < CH; c++) begin
            logic lagged, changed, active;
            if (rst) begin
                m_s1[c]   = NEG;
                m_s2[c]   = NEG;
                m_stb[c]  = NEG;
                m_seen[c] = NEG;
                m_run[c]  = 0;
                m_tog[c]  = RV;
                m_pl[c]   = 1'b0;
                m_sw[c]   = mode_v[c] ? NEG : RV;
            end else begin
                lagged  = m_s2[c];
                m_s2[c] = m_s1[c];
                m_s1[c] = in_v[c];
                if (en) begin
                    changed = (m_stb[c] != m_seen[c]);
                    active  = changed && (m_stb[c] != NEG);
                    m_pl[c] = mode_v[c] ? changed : active;
                    if (clr_v[c]) m_tog[c] = RV;
                    else if (!mode_v[c] && active) m_tog[c] = ~m_tog[c];
                    m_sw[c]   = mode_v[c] ? m_stb[c] : m_tog[c];
                    m_seen[c] = m_stb[c];
                    if (lagged != m_stb[c]) begin
                        m_run[c]++;
                        if (m_run[c] == DB) begin
                            m_stb[c] = lagged;
                            m_run[c] = 0;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end else begin
                    m_pl[c] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        chk_on = 1'b1;
        acc |= pulse_out;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("sw_out", sw_out, m_sw);
            check("pulse_out", pulse_out, m_pl);
        end
    end

    initial begin
        int first_p, second_p, npulse, waited;
        rst = 1'b1; en = 1'b1; in_v = '0; mode_v = '0; clr_v = '0; acc = '0;

        // Reset with inputs high, then release: all toggle channels flip at edge 7.
        in_v = 4'b1111;
        steps(2);
        check("rst_sw", sw_out, 4'b0000);
        check("rst_pulse", pulse_out, 4'b0000);
        rst = 1'b0;
        steps(6);
        check("rel_sw_e6", sw_out, 4'b0000);
        step();
        check("rel_sw_e7", sw_out, 4'b1111);
        check("rel_pulse_e7", pulse_out, 4'b1111);
        step();
        check("rel_pulse_e8", pulse_out, 4'b0000);

        // Press/release/press on ch0 in toggle mode.
        rst = 1'b1; in_v = '0; steps(2); rst = 1'b0; steps(3);
        in_v[0] = 1'b1; steps(10);
        check("press1_sw0", sw_out & 4'b0001, 4'b0001);
        in_v[0] = 1'b0; acc = '0; steps(10);
        check("release_nopulse", acc & 4'b0001, 4'b0000);
        check("release_sw0", sw_out & 4'b0001, 4'b0001);
        in_v[0] = 1'b1; steps(10);
        check("press2_sw0", sw_out & 4'b0001, 4'b0000);
        in_v[0] = 1'b0; steps(10);

        // Short glitch on ch1.
        in_v[1] = 1'b1; acc = '0; steps(3);
        in_v[1] = 1'b0; steps(12);
        check("glitch_pulse1", acc & 4'b0010, 4'b0000);
        check("glitch_sw1", sw_out & 4'b0010, 4'b0000);

        // ch2 in pulse mode: one pulse per level change, 10 cycles apart.
        mode_v = 4'b0100; steps(2);
        first_p = -1; second_p = -1; npulse = 0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 1) in_v[2] = 1'b1;
            if (k == 11) in_v[2] = 1'b0;
            step();
            if (k == 6) check("mode1_sw2_e6", sw_out & 4'b0100, 4'b0000);
            if (k == 7) check("mode1_sw2_e7", sw_out & 4'b0100, 4'b0100);
            if (pulse_out[2]) begin
                npulse++;
                if (first_p < 0) first_p = k; else second_p = k;
            end
        end
        check_int("mode1_npulse", npulse, 2);
        check_int("mode1_first", first_p, 7);
        check_int("mode1_gap", second_p - first_p, 10);
        mode_v = '0; steps(2);

        // clr on ch3 coinciding with its active edge.
        in_v[3] = 1'b1; steps(6);
        clr_v[3] = 1'b1; step();
        check("clr_pulse3", pulse_out & 4'b1000, 4'b1000);
        check("clr_sw3", sw_out & 4'b1000, 4'b0000);
        clr_v[3] = 1'b0; step();
        check("clr_after_pulse3", pulse_out & 4'b1000, 4'b0000);
        check("clr_after_sw3", sw_out & 4'b1000, 4'b0000);

        // Reset in the middle of a debounce window.
        in_v = '0; rst = 1'b1; steps(2); rst = 1'b0; steps(3);
        in_v[0] = 1'b1; steps(4);
        rst = 1'b1; in_v = '0; step(); rst = 1'b0;
        acc = '0; steps(12);
        check("midrst_nopulse", acc, 4'b0000);
        check("midrst_sw", sw_out, 4'b0000);

        // Press while disabled: frozen, then reported a full window after en returns.
        in_v[1] = 1'b1; en = 1'b0; acc = '0; steps(10);
        check("en0_nopulse", acc, 4'b0000);
        check("en0_sw", sw_out, 4'b0000);
        en = 1'b1; waited = 0;
        while (waited < 20) begin
            step();
            waited++;
            if (pulse_out[1]) break;
        end
        check_int("en_return_latency", waited, 5);
        check("en_return_sw1", sw_out & 4'b0010, 4'b0010);

        // Randomized traffic, checked every cycle by the compare process.
        for (int k = 0; k < 1500; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 9) != 0);
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 7) == 0) in_v[c] = ~in_v[c];
                if ($urandom_range(0, 63) == 0) mode_v[c] = ~mode_v[c];
                clr_v[c] = en && ($urandom_range(0, 31) == 0);
            end
            step();
        end
        rst = 1'b0; en = 1'b1; clr_v = '0;
        steps(2);
        @(posedge clk);
        chk_on = 1'b0;
        #2;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
